router_flit_injector: RTL

//  Upstream injection stage for one router input port. Accepts flits from a

---
 rtl/router_pkg.sv | 14 +
 rtl/router_flit_injector_if.sv | 13 +
 rtl/router_flit_fifo.sv | 39 +++
 rtl/router_flit_injector.sv | 84 ++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router injection stage: channel field layout and framing states.
package router_pkg;
  localparam int CH_VALID       = 0;
  localparam int CH_HEAD        = 1;
  localparam int CH_TAIL        = 2;
  localparam int CH_PAYLOAD_LSB = 3;
  localparam int PAYLOAD_W_DEF  = 31;
  localparam int CHANNEL_W      = PAYLOAD_W_DEF + 3;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } frame_state_t;
endpackage

// File: rtl/router_flit_injector_if.sv
// Local source to injector flit handshake (valid/ready plus framing bits and payload).
interface router_flit_injector_if #(
  parameter int PAYLOAD_W = 31
);
  logic                 valid;
  logic                 ready;
  logic                 head;
  logic                 tail;
  logic [0:PAYLOAD_W-1] data;

  modport master (output valid, output head, output tail, output data, input ready);
  modport slave  (input valid, input head, input tail, input data, output ready);
endinterface

// File: rtl/router_flit_fifo.sv
// Synchronous FIFO of {head,tail,payload} entries; extra pointer bit separates full from empty.
module router_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/router_flit_injector.sv
// Injection stage: buffers source flits, checks head/tail framing and drives the router
// channel under credit-based flow control with a sticky error flag.
module router_flit_injector
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_CREDITS = 8,
  parameter int PAYLOAD_W   = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  router_flit_injector_if.slave src,
  output logic [0:PAYLOAD_W+2] channel_out,
  input  logic [0:0]           flow_ctrl_in,
  output logic [0:3]           credit_count,
  output logic                 error
);
  localparam int FW = PAYLOAD_W + 2;

  frame_state_t  state;
  logic          full;
  logic          empty;
  logic          accept;
  logic          frame_ok;
  logic          push;
  logic          pop;
  logic          ret;
  logic [FW-1:0] rdata;

  assign src.ready = reset & ~full;
  assign accept    = src.valid & src.ready;
  assign frame_ok  = (state == IDLE) ? src.head : ~src.head;
  assign push      = accept & frame_ok;
  assign pop       = ~empty & (credit_count != 4'd0);
  assign ret       = flow_ctrl_in[0];

  router_flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({src.head, src.tail, src.data}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      error        <= 1'b0;
      credit_count <= 4'(NUM_CREDITS);
    end else begin
      if (accept) begin
        case (state)
          IDLE: if (src.head && !src.tail) state <= PKT;
          PKT:  if (!src.head && src.tail) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (!frame_ok) error <= 1'b1;
      end
      // A send and a return in the same cycle cancel; a return with a full count overflows.
      if (pop && !ret) begin
        credit_count <= credit_count - 4'd1;
      end else if (ret && !pop) begin
        if (credit_count == 4'(NUM_CREDITS)) error <= 1'b1;
        else credit_count <= credit_count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      channel_out <= '0;
    end else if (pop) begin
      channel_out <= {1'b1, rdata};
    end else begin
      channel_out[CH_VALID] <= 1'b0;
    end
  end
endmodule
